// File: rtl/stepdown_pkg.sv
// stepdown_pkg
//   Shared types and defaults for the step-down converter dead-time
//   controller: FSM state enumeration, default parameter values and the
//   width of the min-on / switch counters.
package stepdown_pkg;

  localparam int unsigned DT_W_DEF   = 4;
  localparam int unsigned MIN_ON_DEF = 3;
  localparam int unsigned CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LS_ON = 3'd1,
    DT_LH = 3'd2,
    HS_ON = 3'd3,
    DT_HL = 3'd4,
    FAULT = 3'd5
  } state_t;

endpackage

// File: rtl/stepdown_dt_counter.sv
// stepdown_dt_counter
//   Loadable down-counter with zero flag. Load has priority over decrement;
//   decrement saturates at zero.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load count from load_val
//   load_val : value to load
//   dec      : decrement by one
//   zero     : count is zero
module stepdown_dt_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/stepdown_deadtime_ctrl.sv
// stepdown_deadtime_ctrl
//   Dead-time controller for a synchronous step-down converter half bridge.
//   Alternates high-side / low-side gate enables with a programmable dead
//   time between them, enforces a minimum high-side on-time, latches faults
//   until acknowledged and counts high-side conduction entries.
//   CELCLK        : clock, rising edge
//   CELRST        : synchronous active-high reset
//   CELV/CELG/SUB : supply, ground, substrate pins (no function)
//   en            : converter enable
//   pwm_req       : 1 = high-side conduction requested, 0 = low-side
//   dt_cfg        : dead time in cycles minus 1 (sampled at counter load)
//   fault         : overcurrent / UVLO fault, level
//   fault_clr     : fault acknowledge
//   hs_on, ls_on  : registered gate enables
//   dt_active     : dead-time interval in progress
//   fault_latched : FAULT state active
//   sw_cnt        : count of HS_ON entries, modulo 256
module stepdown_deadtime_ctrl
  import stepdown_pkg::*;
#(
  parameter int unsigned DT_W   = DT_W_DEF,
  parameter int unsigned MIN_ON = MIN_ON_DEF
) (
  input  logic            CELCLK,
  input  logic            CELRST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            en,
  input  logic            pwm_req,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic            fault,
  input  logic            fault_clr,
  output logic            hs_on,
  output logic            ls_on,
  output logic            dt_active,
  output logic            fault_latched,
  output logic [7:0]      sw_cnt
);

  localparam logic [CNT_W-1:0] MIN_ON_LD = CNT_W'(MIN_ON - 1);

  state_t state;
  state_t nxt;

  logic dt_load, dt_dec, dt_zero;
  logic mo_load, mo_dec, mo_zero;

  // Power pins are present for netlist compatibility only.
  logic unused_pins;
  assign unused_pins = &{1'b0, CELV, CELG, SUB};

  always_comb begin
    nxt     = state;
    dt_load = 1'b0;
    dt_dec  = 1'b0;
    mo_load = 1'b0;
    mo_dec  = 1'b0;
    if (fault) begin
      nxt = FAULT;
    end else if (state == FAULT) begin
      if (fault_clr) nxt = IDLE;
    end else if (!en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:  nxt = LS_ON;
        LS_ON: begin
          if (pwm_req) begin
            nxt     = DT_LH;
            dt_load = 1'b1;
          end
        end
        DT_LH: begin
          if (dt_zero) begin
            nxt     = HS_ON;
            mo_load = 1'b1;
          end else begin
            dt_dec = 1'b1;
          end
        end
        HS_ON: begin
          if (!pwm_req && mo_zero) begin
            nxt     = DT_HL;
            dt_load = 1'b1;
          end else begin
            mo_dec = 1'b1;
          end
        end
        DT_HL: begin
          if (dt_zero) nxt = LS_ON;
          else         dt_dec = 1'b1;
        end
        default: nxt = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state register without an extra cycle of latency.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      state         <= IDLE;
      hs_on         <= 1'b0;
      ls_on         <= 1'b0;
      dt_active     <= 1'b0;
      fault_latched <= 1'b0;
      sw_cnt        <= '0;
    end else begin
      state         <= nxt;
      hs_on         <= (nxt == HS_ON);
      ls_on         <= (nxt == LS_ON);
      dt_active     <= (nxt == DT_LH) || (nxt == DT_HL);
      fault_latched <= (nxt == FAULT);
      if ((nxt == HS_ON) && (state != HS_ON)) sw_cnt <= sw_cnt + 8'd1;
    end
  end

  stepdown_dt_counter #(.W(DT_W)) u_dt_cnt (
    .clk      (CELCLK),
    .rst      (CELRST),
    .load     (dt_load),
    .load_val (dt_cfg),
    .dec      (dt_dec),
    .zero     (dt_zero)
  );

  stepdown_dt_counter #(.W(CNT_W)) u_mo_cnt (
    .clk      (CELCLK),
    .rst      (CELRST),
    .load     (mo_load),
    .load_val (MIN_ON_LD),
    .dec      (mo_dec),
    .zero     (mo_zero)
  );

endmodule

// File: tb/tb_stepdown_deadtime_ctrl.sv
// tb_stepdown_deadtime_ctrl
//   Directed and randomised checks of stepdown_deadtime_ctrl with DT_W=4,
//   MIN_ON=3. A background monitor checks gate exclusivity and handover gaps.
module tb_stepdown_deadtime_ctrl;

  logic       clk = 1'b0;
  logic       rst, en, pwm, fault, clr;
  logic [3:0] dt;
  logic       hs_on, ls_on, dt_active, fault_latched;
  logic [7:0] sw_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stepdown_deadtime_ctrl #(.DT_W(4), .MIN_ON(3)) dut (
    .CELCLK        (clk),
    .CELRST        (rst),
    .CELV          (1'b1),
    .CELG          (1'b0),
    .SUB           (1'b0),
    .en            (en),
    .pwm_req       (pwm),
    .dt_cfg        (dt),
    .fault         (fault),
    .fault_clr     (clr),
    .hs_on         (hs_on),
    .ls_on         (ls_on),
    .dt_active     (dt_active),
    .fault_latched (fault_latched),
    .sw_cnt        (sw_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Monitor: exclusivity every cycle; on each clean hs<->ls handover the
  // all-off gap must equal the dt_cfg value loaded at the start of it, plus 1.
  logic [3:0] prev_dt   = '0;
  logic       prev_dta  = 1'b0;
  logic       prev_hs   = 1'b0;
  logic       prev_ls   = 1'b0;
  logic       last_side = 1'b0;
  logic       clean     = 1'b0;
  int         gap       = 0;
  int         need      = 0;

  always @(negedge clk) begin
    n_assert++;
    assert (!(hs_on && ls_on)) else begin
      n_fail++;
      $error("FAIL overlap: hs_on=%0b ls_on=%0b required not both 1", hs_on, ls_on);
    end
    if (dt_active && !prev_dta) need = int'(prev_dt) + 1;
    if (hs_on || ls_on) begin
      if (((hs_on && !prev_hs) || (ls_on && !prev_ls)) && clean && (last_side != hs_on)) begin
        n_assert++;
        assert (gap == need) else begin
          n_fail++;
          $error("FAIL handover_gap: observed %0d expected %0d", gap, need);
        end
      end
      last_side = hs_on;
      gap       = 0;
      clean     = 1'b1;
    end else if (dt_active) begin
      gap++;
    end else begin
      clean = 1'b0;
    end
    prev_dta = dt_active;
    prev_hs  = hs_on;
    prev_ls  = ls_on;
    prev_dt  = dt;
  end

  initial begin
    rst = 1'b1; en = 1'b1; pwm = 1'b0; dt = 4'd2; fault = 1'b0; clr = 1'b0;
    #1;
    step(); step();
    chkb("rst_hs", hs_on, 1'b0);
    chkb("rst_ls", ls_on, 1'b0);
    chkb("rst_dt", dt_active, 1'b0);
    chkb("rst_flt", fault_latched, 1'b0);
    chk ("rst_sw", sw_cnt, 8'd0);

    // Reset release with en=1: IDLE -> LS_ON.
    rst = 1'b0;
    step();
    chkb("start_ls", ls_on, 1'b1);
    chkb("start_hs", hs_on, 1'b0);
    chk ("start_sw", sw_cnt, 8'd0);

    // One-cycle pwm pulse, dt_cfg=2: 3 dead cycles, then 3 min-on cycles.
    pwm = 1'b1;
    step();
    chkb("lh_ls_fall", ls_on, 1'b0);
    chkb("lh_dt1", dt_active, 1'b1);
    chkb("lh_hs1", hs_on, 1'b0);
    pwm = 1'b0;
    step();
    chkb("lh_dt2", dt_active, 1'b1);
    chkb("lh_hs2", hs_on, 1'b0);
    step();
    chkb("lh_dt3", dt_active, 1'b1);
    chkb("lh_hs3", hs_on, 1'b0);
    step();
    chkb("hs_rise", hs_on, 1'b1);
    chkb("lh_dt_end", dt_active, 1'b0);
    chk ("sw_one", sw_cnt, 8'd1);
    step();
    chkb("minon_2", hs_on, 1'b1);
    step();
    chkb("minon_3", hs_on, 1'b1);
    step();
    chkb("minon_end", hs_on, 1'b0);
    chkb("hl_dt1", dt_active, 1'b1);
    dt = 4'd0;  // change after load must not shorten this interval
    step();
    chkb("hl_dt2", dt_active, 1'b1);
    step();
    chkb("hl_dt3", dt_active, 1'b1);
    chkb("hl_ls_off", ls_on, 1'b0);
    step();
    chkb("hl_ls_back", ls_on, 1'b1);
    chkb("hl_dt_end", dt_active, 1'b0);

    // dt_cfg=0 handover, then fault during HS_ON.
    pwm = 1'b1;
    step();
    chkb("dt0_dt", dt_active, 1'b1);
    step();
    chkb("dt0_hs", hs_on, 1'b1);
    chk ("sw_two", sw_cnt, 8'd2);
    fault = 1'b1;
    step();
    chkb("flt_hs", hs_on, 1'b0);
    chkb("flt_latch", fault_latched, 1'b1);
    clr = 1'b1;
    step();
    chkb("flt_clr_held", fault_latched, 1'b1);
    fault = 1'b0;
    step();
    chkb("flt_exit", fault_latched, 1'b0);
    chkb("flt_idle_ls", ls_on, 1'b0);
    clr = 1'b0; pwm = 1'b0;
    step();
    chkb("flt_to_ls", ls_on, 1'b1);

    // Enable drop.
    en = 1'b0;
    step();
    chkb("en_off_ls", ls_on, 1'b0);
    en = 1'b1;
    step();
    chkb("en_on_ls", ls_on, 1'b1);

    // Reset mid-HS_ON clears everything; min-on restarts cleanly afterwards.
    pwm = 1'b1;
    step(); step();
    chk ("sw_three", sw_cnt, 8'd3);
    rst = 1'b1;
    step();
    chkb("mid_rst_hs", hs_on, 1'b0);
    chk ("mid_rst_sw", sw_cnt, 8'd0);
    chkb("mid_rst_dt", dt_active, 1'b0);
    rst = 1'b0;
    step();
    chkb("post_rst_ls", ls_on, 1'b1);
    step();
    chkb("post_rst_dt", dt_active, 1'b1);
    step();
    chkb("post_rst_hs", hs_on, 1'b1);
    chk ("post_rst_sw", sw_cnt, 8'd1);
    pwm = 1'b0;
    step();
    chkb("post_rst_mo2", hs_on, 1'b1);
    step();
    chkb("post_rst_mo3", hs_on, 1'b1);
    step();
    chkb("post_rst_mo_end", hs_on, 1'b0);
    step();
    chkb("post_rst_ls_back", ls_on, 1'b1);

    // sw_cnt wrap after 256 HS_ON entries.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 256; i++) begin
      pwm = 1'b1;
      for (int k = 0; k < 10 && !hs_on; k++) step();
      chkb("wrap_hs_reach", hs_on, 1'b1);
      pwm = 1'b0;
      for (int k = 0; k < 10 && !ls_on; k++) step();
      chkb("wrap_ls_reach", ls_on, 1'b1);
      if (i == 254) chk("wrap_255", sw_cnt, 8'd255);
    end
    chk("wrap_0", sw_cnt, 8'd0);

    // Random traffic; the monitor does the checking.
    for (int c = 0; c < 10000; c++) begin
      en    = ($urandom_range(0, 31) != 0);
      fault = ($urandom_range(0, 99) == 0);
      clr   = 1'($urandom_range(0, 1));
      dt    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) pwm = ~pwm;
      step();
    end

    fault = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
